unsigned_mac_accumulator_8: RTL
===============================

# unsigned_mac_accumulator_8

Streaming multiply-accumulate back end for the 8x8 unsigned Dadda/CLA multiplier. It sits directly downstream of the multiplier and consumes its 16-bit `product` through a valid/ready handshake. It sums a run of products (a dot product) into a wide accumulator and presents each finished sum, with term count and overflow flag, on a registered valid/ready output port.

## Interface

Parameters:
- `ACC_W`, 24: accumulator and `out_sum` width; legal range 16..32.
- `LEN`, 8: maximum number of terms per dot product; legal range 1..255.
- `CNT_W`, 8: width of the term counter and `out_count`; must satisfy 2^CNT_W > LEN.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: `in_product` and `in_last` are valid.
- `in_ready`, out, 1: block accepts a term this cycle.
- `in_product`, in, 16: unsigned product from the multiplier.
- `in_last`, in, 1: this term ends the dot product early.
- `out_valid`, out, 1: result registers hold a finished dot product.
- `out_ready`, in, 1: downstream consumes the result.
- `out_sum`, out, ACC_W: accumulated sum, modulo 2^ACC_W.
- `out_count`, out, CNT_W: number of terms in `out_sum`, from 1 to LEN.
- `out_overflow`, out, 1: sticky flag; set if any addition in this dot product carried out of ACC_W.

## Operation

- State machine has two states, ACCUM and HOLD.
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Accept: a term is accepted when `in_valid && in_ready`.
- On each accept in ACCUM:
  - next = acc + zero-extended `in_product`, truncated to ACC_W bits.
  - The carry-out of that addition ORs into the running overflow flag.
  - cnt increments by 1.
- Terminating accept: an accept with `in_last`=1, or an accept when cnt == LEN-1.
  - `out_sum` is loaded with next, `out_count` with cnt+1, `out_overflow` with the updated flag.
  - acc, cnt and the flag clear to 0.
  - State goes to HOLD.
  - If `in_last`=1 and cnt == LEN-1 occur together, there is a single termination with `out_count`=LEN.
- Non-terminating accept: acc, cnt and flag update; state stays ACCUM.
- HOLD: output registers hold steady. When `out_ready`=1, state returns to ACCUM on the next edge. Inputs are ignored while in HOLD.
- No accept in ACCUM: all state holds.
- `in_product` = 0 is a legal term; it is counted and produces no carry.

## Timing

- Reset values:
  - State = ACCUM.
  - `in_ready`=1, `out_valid`=0.
  - `out_sum`=0, `out_count`=0, `out_overflow`=0.
  - Internal acc, cnt and flag = 0.
- Reset mid-run or while in HOLD discards partial and pending results and takes effect on the same edge. Reset has priority over every other event.
- Latency: `out_valid` rises in the cycle after the terminating accept.
- Throughput:
  - One term per cycle inside ACCUM.
  - The minimum gap between dot products is 1 cycle (the HOLD cycle with `out_ready`=1), so a LEN-term dot product takes at least LEN+1 cycles.
- `in_ready` and `out_valid` are decoded from the state register only, with no combinational path from `in_valid` or `out_ready`.
- While `out_valid`=1 and `out_ready`=0, `out_sum`, `out_count` and `out_overflow` are stable.
- All outputs are registered or state-decoded. The only combinational path is acc + `in_product` into the registers.

## Test plan

- Reset, then 8 consecutive accepts of 0xFE01 (255*255), LEN=8, ACC_W=24, `out_ready`=1:
  - One cycle after the 8th accept: `out_valid`=1, `out_sum`=0x07F008, `out_count`=8, `out_overflow`=0.
  - `in_ready`=0 in that cycle and returns to 1 on the next cycle.
- Terms 3, 5, 7 with `in_last` set on the term 7:
  - `out_sum`=15, `out_count`=3.
  - The next dot product starts from acc=0: a following single term 9 with `in_last` gives `out_sum`=9, `out_count`=1.
- ACC_W=16, terms 0xFE01, 0xFE01 with `in_last` on the second:
  - `out_sum`=0xFC02, `out_overflow`=1.
  - The next dot product (term 1 with `in_last`) gives `out_overflow`=0.
- Backpressure: finish a dot product with `out_ready`=0 for 5 cycles while `in_valid`=1:
  - `out_valid`, `out_sum` and `out_count` are stable, and `in_ready`=0 throughout.
  - No term is lost or double-counted once `out_ready` rises.
- `in_last`=1 on the 8th term with LEN=8: exactly one result, `out_count`=8.
- Assert `rst` for one cycle after 4 accepted terms:
  - All outputs return to reset values.
  - The next 8 terms of value 1 give `out_sum`=8.

Source files
------------

// File: rtl/unsigned_mac_accumulator_8.sv
// unsigned_mac_accumulator_8: streaming multiply-accumulate back end that sums runs of 16-bit products
// and presents each finished dot product on a registered valid/ready port.
module unsigned_mac_accumulator_8 #(
   parameter int ACC_W = 24,
   parameter int LEN   = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow
);
   typedef enum logic {ACCUM, HOLD} state_t;
   state_t state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, next_sum;
   logic [CNT_W-1:0] cnt_q, cnt_d, count_q, count_d;
   logic             ovf_q, ovf_d, oflag_q, oflag_d, carry, accept, term;
   // One extra bit catches the carry-out for the sticky overflow flag.
   assign {carry, next_sum} = {1'b0, acc_q} + {{(ACC_W-15){1'b0}}, in_product};
   assign accept = in_valid && (state_q == ACCUM);
   assign term   = in_last || (cnt_q == CNT_W'(LEN-1));
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      sum_d   = sum_q;
      count_d = count_q;
      oflag_d = oflag_q;
      if (accept && term) begin
         sum_d   = next_sum;
         count_d = cnt_q + 1'b1;
         oflag_d = ovf_q | carry;
         acc_d   = '0;
         cnt_d   = '0;
         ovf_d   = 1'b0;
         state_d = HOLD;
      end else if (accept) begin
         acc_d = next_sum;
         cnt_d = cnt_q + 1'b1;
         ovf_d = ovf_q | carry;
      end else if (state_q == HOLD && out_ready) begin
         state_d = ACCUM;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ACCUM;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sum_q   <= '0;
         count_q <= '0;
         oflag_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         oflag_q <= oflag_d;
      end
   end
   assign in_ready     = (state_q == ACCUM);
   assign out_valid    = (state_q == HOLD);
   assign out_sum      = sum_q;
   assign out_count    = count_q;
   assign out_overflow = oflag_q;
endmodule
